// File: rtl/serial_mult_arbiter.sv
// Round-robin arbiter sharing one serial multiplier among NREQ requesters, with a watchdog abort.
// Latency: ack/mul_en one cycle after req is sampled in IDLE; response one cycle after mul_valid is sampled.
// Backpressure: one operation outstanding; other requests wait in IDLE and are re-arbitrated there.
module serial_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           ack,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_data,
    output logic                      rsp_err,
    output logic                      mul_rst_n,
    output logic                      mul_en,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic                      mul_valid,
    input  logic [2*WIDTH-1:0]        mul_s
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort is decided in the cycle whose increment would bring the counter to TIMEOUT-1,
    // so the error response lands exactly TIMEOUT cycles after the ISSUE cycle.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    last;      // most recent winner; also the id of the operation in flight
    logic [CNT_W-1:0]   wd_cnt;

    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic [NREQ-1:0]    win_onehot;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic [SUM_W-1:0]   scan_sum;
    logic [ID_W-1:0]    scan_idx;

    // Round-robin pick: scan downward from last+NREQ to last+1 so the lowest offset wins.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_sum = {1'b0, last} + SUM_W'(k);
            if (scan_sum >= SUM_W'(NREQ)) begin
                scan_sum = scan_sum - SUM_W'(NREQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    // Winner's one-hot ack and operand mux.
    always_comb begin
        win_onehot = '0;
        win_a      = '0;
        win_b      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_vld && (win_id == ID_W'(i))) begin
                win_onehot[i] = 1'b1;
                win_a         = req_a[i*WIDTH +: WIDTH];
                win_b         = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(NREQ - 1);
            wd_cnt    <= '0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mul_en    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_rst_n <= 1'b0;
        end else begin
            ack       <= '0;
            mul_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            mul_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state  <= ISSUE;
                        last   <= win_id;
                        ack    <= win_onehot;
                        mul_en <= 1'b1;
                        mul_a  <= win_a;
                        mul_b  <= win_b;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT_LO;
                end
                WAIT_LO: begin
                    // A valid still high here belongs to the previous operation.
                    if (wd_cnt == WD_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= last;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        mul_rst_n <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (!mul_valid) begin
                            state <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    // Completion takes precedence over a watchdog expiring in the same cycle.
                    if (mul_valid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= last;
                        rsp_data  <= mul_s;
                    end else if (wd_cnt == WD_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= last;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        mul_rst_n <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mult_arbiter.sv
// Directed bench for serial_mult_arbiter with a behavioural serial multiplier model.
// Latency: model raises valid a fixed number of cycles after mul_en, or never in hang mode.
// Backpressure: requesters drop req after ack unless a step deliberately holds it.
module tb_serial_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  ack;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mul_rst_n;
    logic        mul_en;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_valid;
    logic [15:0] mul_s;

    logic [7:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    assign req_a = {a3, a2, a1, a0};
    assign req_b = {b3, b2, b1, b0};

    int checks  = 0;
    int errors  = 0;
    int exp_ops = 0;
    int en_cnt  = 0;
    int n;
    int rsp_seen;

    logic        stale_mode = 1'b0;
    logic        hang_mode  = 1'b0;
    logic        mdl_busy;
    int          mdl_cnt;
    logic [7:0]  mdl_a;
    logic [7:0]  mdl_b;

    always #5 clk = ~clk;

    serial_mult_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_rst_n (mul_rst_n),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_s     (mul_s)
    );

    // Multiplier model: valid is a level that stays high until the next start (or longer in stale mode).
    always @(posedge clk) begin
        if (!mul_rst_n) begin
            mul_valid <= 1'b0;
            mul_s     <= '0;
            mdl_busy  <= 1'b0;
            mdl_cnt   <= 0;
        end else if (mul_en) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 0;
            mdl_a    <= mul_a;
            mdl_b    <= mul_b;
            if (!stale_mode) mul_valid <= 1'b0;
        end else if (mdl_busy) begin
            mdl_cnt <= mdl_cnt + 1;
            if (stale_mode && mdl_cnt == 2) mul_valid <= 1'b0;
            if (!hang_mode && mdl_cnt == LAT) begin
                mul_valid <= 1'b1;
                mul_s     <= {8'd0, mdl_a} * {8'd0, mdl_b};
                mdl_busy  <= 1'b0;
            end
        end
    end

    // Count start pulses so a stretched or duplicated mul_en shows up.
    always @(posedge clk) begin
        if (mul_en === 1'b1) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp_ack,
                            input logic [7:0] exp_a, input logic [7:0] exp_b, output int cyc);
        cyc = 0;
        while (ack === 4'b0000 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        exp_ops++;
        check({tag, "_ack"},    32'(ack),    32'(exp_ack));
        check({tag, "_mul_en"}, 32'(mul_en), 32'd1);
        check({tag, "_mul_ab"}, 32'({mul_a, mul_b}), 32'({exp_a, exp_b}));
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] exp_id,
                            input logic [15:0] exp_data, input logic exp_err, output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'(exp_id));
        check({tag, "_rsp_data"},  32'(rsp_data),  32'(exp_data));
        check({tag, "_rsp_err"},   32'(rsp_err),   32'(exp_err));
        check({tag, "_en_pulses"}, 32'(en_cnt),    32'(exp_ops));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        a0 = 0; a1 = 0; a2 = 0; a3 = 0;
        b0 = 0; b1 = 0; b2 = 0; b3 = 0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ctl",  32'({ack, rsp_valid, rsp_id, rsp_err, mul_en, mul_rst_n}), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_ops",  32'({mul_a, mul_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mul_rst_n_release", 32'(mul_rst_n), 32'd1);

        // Single request: 13*11
        a0 = 8'd13; b0 = 8'd11; req = 4'b0001;
        wait_ack("single", 4'b0001, 8'd13, 8'd11, n);
        req = 4'b0000;
        check("single_grant_lat", 32'(n), 32'd1);
        wait_rsp("single", 2'd0, 16'd143, 1'b0, n);
        check("single_rsp_lat", 32'(n), 32'd7);

        // Round-robin from a fresh reset with all four requesting continuously
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a0 = 8'd255; b0 = 8'd255; a1 = 8'd0;   b1 = 8'd77;
        a2 = 8'd1;   b2 = 8'd200; a3 = 8'd128; b3 = 8'd2;
        req = 4'b1111;
        wait_ack("rr0", 4'b0001, 8'd255, 8'd255, n);
        wait_rsp("rr0", 2'd0, 16'd65025, 1'b0, n);
        wait_ack("rr1", 4'b0010, 8'd0, 8'd77, n);
        check("rr_next_grant_lat", 32'(n), 32'd2);
        wait_rsp("rr1", 2'd1, 16'd0, 1'b0, n);
        wait_ack("rr2", 4'b0100, 8'd1, 8'd200, n);
        wait_rsp("rr2", 2'd2, 16'd200, 1'b0, n);
        wait_ack("rr3", 4'b1000, 8'd128, 8'd2, n);
        wait_rsp("rr3", 2'd3, 16'd256, 1'b0, n);
        wait_ack("rr4", 4'b0001, 8'd255, 8'd255, n);
        req = 4'b0000;
        wait_rsp("rr4", 2'd0, 16'd65025, 1'b0, n);

        // Fairness: make last=1, then 1001 must go to 3 before 0
        a1 = 8'd3; b1 = 8'd5; req = 4'b0010;
        wait_ack("fa_last1", 4'b0010, 8'd3, 8'd5, n);
        req = 4'b0000;
        wait_rsp("fa_last1", 2'd1, 16'd15, 1'b0, n);
        req = 4'b1001;
        wait_ack("fa_skip3", 4'b1000, 8'd128, 8'd2, n);
        req = 4'b0001;
        wait_rsp("fa_skip3", 2'd3, 16'd256, 1'b0, n);
        wait_ack("fa_wrap0", 4'b0001, 8'd255, 8'd255, n);
        req = 4'b0000;
        wait_rsp("fa_wrap0", 2'd0, 16'd65025, 1'b0, n);

        // Requester 2 raises mid-operation while 0 waits; with last=1, 2 goes first
        req = 4'b0011;
        wait_ack("fa_mid1", 4'b0010, 8'd3, 8'd5, n);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        req = 4'b0101;
        wait_rsp("fa_mid1", 2'd1, 16'd15, 1'b0, n);
        wait_ack("fa_mid2", 4'b0100, 8'd1, 8'd200, n);
        req = 4'b0001;
        wait_rsp("fa_mid2", 2'd2, 16'd200, 1'b0, n);
        wait_ack("fa_mid0", 4'b0001, 8'd255, 8'd255, n);
        req = 4'b0000;
        wait_rsp("fa_mid0", 2'd0, 16'd65025, 1'b0, n);

        // Stale valid: old product 65025 stays visible for 3 cycles after the new start
        stale_mode = 1'b1;
        a1 = 8'd7; b1 = 8'd9; req = 4'b0010;
        wait_ack("stale", 4'b0010, 8'd7, 8'd9, n);
        req = 4'b0000;
        wait_rsp("stale", 2'd1, 16'd63, 1'b0, n);
        check("stale_rsp_lat", 32'(n), 32'd7);
        stale_mode = 1'b0;

        // Timeout: multiplier never completes
        hang_mode = 1'b1;
        a2 = 8'd10; b2 = 8'd10; req = 4'b0100;
        wait_ack("timeout", 4'b0100, 8'd10, 8'd10, n);
        req = 4'b0000;
        wait_rsp("timeout", 2'd2, 16'd0, 1'b1, n);
        check("timeout_lat", 32'(n), 32'd16);
        check("timeout_mul_rst_n_low", 32'(mul_rst_n), 32'd0);
        hang_mode = 1'b0;
        @(negedge clk);
        check("timeout_mul_rst_n_high", 32'(mul_rst_n), 32'd1);
        check("timeout_rsp_single", 32'({rsp_valid, rsp_err}), 32'd0);
        a3 = 8'd12; b3 = 8'd12; req = 4'b1000;
        wait_ack("post_timeout", 4'b1000, 8'd12, 8'd12, n);
        req = 4'b0000;
        wait_rsp("post_timeout", 2'd3, 16'd144, 1'b0, n);
        check("post_timeout_lat", 32'(n), 32'd7);

        // Reset while waiting for the product
        a0 = 8'd2; b0 = 8'd3; req = 4'b0001;
        wait_ack("rst_mid", 4'b0001, 8'd2, 8'd3, n);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        a0 = 8'd6; b0 = 8'd7; req = 4'b1111;
        rsp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        check("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
        check("rst_mid_ctl",  32'({ack, rsp_valid, rsp_id, rsp_err, mul_en, mul_rst_n}), 32'd0);
        check("rst_mid_data", 32'(rsp_data), 32'd0);
        check("rst_mid_ops",  32'({mul_a, mul_b}), 32'd0);
        rst = 1'b0;
        wait_ack("rst_first_grant", 4'b0001, 8'd6, 8'd7, n);
        req = 4'b0000;
        wait_rsp("rst_first_grant", 2'd0, 16'd42, 1'b0, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mult_arbiter.md
# serial_mult_arbiter

Shares one `serial_multiplier_8_C_Skip_A` instance among `NREQ` requesters. Requests are granted round-robin. The block launches each operation with a single-cycle `en` pulse and waits for the multiplier's `valid`. It returns the product to the granted requester, tagged with its id. A watchdog aborts a hung operation, resets the multiplier and reports an error.

## Interface
- `WIDTH`, 8, operand width; must match the multiplier's `width`
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, cycles allowed in the wait states before abort
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `req` in `NREQ`: per-requester request level
- `req_a` in `NREQ*WIDTH`: operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b` in `NREQ*WIDTH`: operand B, same packing as `req_a`
- `ack` out `NREQ`: one-cycle pulse, operands of requester i captured
- `rsp_valid` out 1: one-cycle pulse, response present
- `rsp_id` out `clog2(NREQ)`: requester the response belongs to
- `rsp_data` out `2*WIDTH`: unsigned product
- `rsp_err` out 1: set with `rsp_valid` on timeout abort
- `mul_rst_n` out 1: multiplier reset, active-low
- `mul_en` out 1: multiplier start pulse
- `mul_a` out `WIDTH`: multiplier operand A
- `mul_b` out `WIDTH`: multiplier operand B
- `mul_valid` in 1: multiplier done level
- `mul_s` in `2*WIDTH`: multiplier product

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- **IDLE:**
  - If any `req` is high, pick the winner and go to ISSUE.
  - The winner is the first set bit scanning upward (with wrap) from `last+1`.
  - Latch the winner's id and operands; set `last` to the winner.
  - If no `req` is high, stay in IDLE.
- **ISSUE (1 cycle):**
  - `mul_en`=1 and `ack[id]`=1.
  - `mul_a`/`mul_b` hold the latched operands from ISSUE until the next grant.
  - Next state WAIT_LO.
- **WAIT_LO:**
  - Go to WAIT_HI once `mul_valid`=0 is sampled.
  - This rejects a stale `valid` left high by the previous operation.
- **WAIT_HI:** on `mul_valid`=1, capture `mul_s` and go to RESP.
- **Watchdog:**
  - The counter clears on entry to WAIT_LO and increments every cycle in WAIT_LO/WAIT_HI.
  - When it reaches `TIMEOUT-1` without completion, go to RESP with the error flag set.
  - If completion is sampled in that same cycle, completion wins.
- **RESP (1 cycle):**
  - `rsp_valid`=1, `rsp_id`=id.
  - Normal completion: `rsp_data` = captured product, `rsp_err`=0.
  - Error: `rsp_data`=0, `rsp_err`=1, and `mul_rst_n`=0 for this cycle.
  - Next state IDLE.
- **Requester rules:**
  - A requester must drop `req` in the cycle after its `ack`.
  - A `req` still high when IDLE is re-entered is treated as a new request.
  - Changes on non-granted `req` lines while busy have no effect until IDLE.
- **Reset:**
  - `rst` in any state, including mid-operation, forces IDLE.
  - `last`=`NREQ-1`, so requester 0 has priority first.
  - Any in-flight result is discarded and no response is produced.
- **Reset values:**
  - 0: `ack`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `mul_en`, `mul_a`, `mul_b`, `mul_rst_n`.
  - `mul_rst_n` goes to 1 in the first cycle after `rst` deasserts.

## Timing
- All outputs are registered.
- **Grant to start:** `req` sampled high in IDLE at edge t → `ack` and `mul_en` high for cycle t+1.
- **Completion to response:** `mul_valid` sampled high in WAIT_HI at edge c → `rsp_valid` high for cycle c+1.
- **Next grant:** the earliest next grant is sampled at edge c+2, with `mul_en` high in cycle c+3.
- **Pulse widths:** `mul_en` is exactly 1 cycle per operation; it is never asserted outside ISSUE.
- **Outstanding operations:** at most one.
- **Abort latency:** `rsp_err` arrives `TIMEOUT` cycles after ISSUE.

## Test plan
- **Single request:** `req`=0001, A0=13, B0=11.
  - `ack`=0001 and one `mul_en` pulse.
  - `rsp_valid` with `rsp_id`=0, `rsp_data`=143, `rsp_err`=0.
- **Round-robin, all requesting:** `req`=1111 held continuously after each `ack`.
  - Grant order 0,1,2,3,0.
  - Operands (255,255), (0,77), (1,200), (128,2) → 65025, 0, 200, 256.
- **Fairness skip:** `last`=1, `req`=1001 → grant 3, then 0.
  - Requester 2 raising `req` mid-operation is granted next, ahead of 0 if `last`=1.
- **Stale valid:** model holds `mul_valid`=1 for 3 cycles after `mul_en` before dropping.
  - The old product is not returned; the response carries the new product.
- **Timeout:** model never raises `mul_valid`, `TIMEOUT`=16.
  - `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, 16 cycles after ISSUE.
  - `mul_rst_n` low for 1 cycle; the next request completes normally.
- **Reset mid-operation:** assert `rst` in WAIT_HI.
  - No `rsp_valid`; all outputs 0.
  - With `req`=1111, the first grant after reset goes to requester 0.
